// File: rtl/adder_pipe.sv
// Pipelined ripple-chunk adder/subtractor with valid/ready handshake.
// Stage k adds operand chunk k. The remaining upper operand bits shift down one chunk per stage.
module adder_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}});

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_ovf;

    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_v_in  [STAGES];
    logic [CW:0]      w_add   [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_vld [STAGES];
    logic             r_ovf;

    assign w_adv    = !r_vld[LAST] || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int unsigned SH = k * CW;
            if (k == 0) begin : g_first
                assign w_a_in[k] = a;
                assign w_b_in[k] = w_b_eff;
                assign w_s_in[k] = '0;
                assign w_c_in[k] = w_c0;
                assign w_v_in[k] = in_valid;
            end else begin : g_next
                assign w_a_in[k] = r_a[k-1];
                assign w_b_in[k] = r_b[k-1];
                assign w_s_in[k] = r_sum[k-1];
                assign w_c_in[k] = r_c[k-1];
                assign w_v_in[k] = r_vld[k-1];
            end
            assign w_add[k] = {1'b0, w_a_in[k][CW-1:0]} + {1'b0, w_b_in[k][CW-1:0]}
                            + {{CW{1'b0}}, w_c_in[k]};
            // Insert this stage's chunk. Lower chunks pass through unchanged.
            assign w_s_nxt[k] = (w_s_in[k] & ~(CHUNK_MASK << SH))
                              | (WIDTH'(w_add[k][CW-1:0]) << SH);
        end
    endgenerate

    // The last stage still sees the original operand MSBs in bit CW-1.
    assign w_ovf = (w_a_in[LAST][CW-1] == w_b_in[LAST][CW-1])
                && (w_add[LAST][CW-1] != w_a_in[LAST][CW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_c[i]   <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_vld[i] <= w_v_in[i];
                r_c[i]   <= w_add[i][CW];
                r_a[i]   <= w_a_in[i] >> CW;
                r_b[i]   <= w_b_in[i] >> CW;
                r_sum[i] <= w_s_nxt[i];
            end
            r_ovf <= w_ovf;
        end
    end

    assign out_valid = r_vld[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits, minimum 2.
REQ-002 The block SHALL have parameter STAGES, default 4: pipeline depth, 1..WIDTH; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1: the operand set on a/b/cin/sub is valid.
REQ-006 The block SHALL have port in_ready, output, 1: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH: operand A.
REQ-008 The block SHALL have port b, input, WIDTH: operand B.
REQ-009 The block SHALL have port cin, input, 1: carry-in, used in add mode only.
REQ-010 The block SHALL have port sub, input, 1: mode select, 0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid, output, 1: the result outputs hold a valid result.
REQ-012 The block SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH: the result.
REQ-014 The block SHALL have port cout, output, 1: carry out of the MSB.
REQ-015 The block SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 An input transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising clk edge with out_valid=1 and out_ready=1.
REQ-017 The pipeline advance enable SHALL be adv = !out_valid | out_ready, and in_ready SHALL equal adv combinationally.
REQ-018 In add mode, the effective operand SHALL be b_eff = b and the carry-in c0 = cin; in subtract mode, b_eff = ~b and c0 = 1, with cin ignored.
REQ-019 The operands SHALL be split into STAGES chunks of WIDTH/STAGES bits each, and stage k SHALL add chunk k of a and b_eff plus the carry registered from stage k-1 (c0 for stage 0).
REQ-020 Each stage SHALL register its chunk sum, its carry, a valid bit, and the not-yet-consumed upper operand chunks; lower result chunks SHALL be carried forward unchanged.
REQ-021 All stage registers SHALL update only when adv=1; when adv=0, every stage SHALL hold its value (global stall, no loss, no duplication).
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when out_ready stays 1, and throughput SHALL be one result per cycle.
REQ-023 A bubble (adv=1 with in_valid=0) SHALL propagate as a stage valid bit of 0; results SHALL emerge in acceptance order.
REQ-024 The outputs SHALL be sum = (a + b_eff + c0) mod 2^WIDTH and cout = bit WIDTH of that addition; in subtract mode, cout=1 SHALL mean no borrow (a >= b unsigned).
REQ-025 The outputs SHALL be ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
REQ-026 sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 With STAGES=1, the block SHALL be a single registered adder with latency 1.

Reset
REQ-028 While rst_n=0, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 immediately (asynchronously), and in_ready SHALL be 1.
REQ-029 Assertion of rst_n mid-operation SHALL discard all in-flight operand sets, and no result for them SHALL appear after release.
REQ-030 The first input transfer SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification (WIDTH=16, STAGES=4)
REQ-031 The bench SHALL drive a=0xFFFF, b=0x0001, cin=0, sub=0 with out_ready=1 -> out_valid rises exactly 4 cycles later with sum=0x0000, cout=1, ovf=0.
REQ-032 The bench SHALL drive a=0x7FFF, b=0x0001, sub=0, then a=0x0005, b=0x0007, sub=1 on consecutive cycles -> results 0x8000/cout=0/ovf=1, then 0xFFFE/cout=0/ovf=0, on consecutive cycles.
REQ-033 The bench SHALL stream 8 random operand sets with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, and all 8 results are correct, in order, and none dropped or duplicated.
REQ-034 The bench SHALL pulse rst_n low for 1 cycle while 3 operand sets are in flight -> outputs are 0 during reset, no stale result appears afterwards, and a new set issues 4 cycles after its transfer.
REQ-035 The bench SHALL drive cin=1 with sub=0, a=0x00FF, b=0x0000, and cin=1 with sub=1, a=0x0003, b=0x0003 -> results 0x0100, then 0x0000 with cout=1 (cin ignored).
REQ-036 The bench SHALL repeat the REQ-031 and REQ-033 scenarios with STAGES=1 and STAGES=16 -> latencies 1 and 16 with identical results.
